// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory port and decode-side handshake.
// The master modport is the fetch unit; the slave modport is the surrounding core/memory.
interface fetch_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_next;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_next
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_next
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited sequential prefetch into a FIFO, with
// redirect flushing the buffer and killing the single in-flight memory response.
module fetch_unit #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int PC_STEP   = 1,
    parameter int BUF_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] pend_pc_r;
    logic              pending_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] inst_mem_r [BUF_DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [BUF_DEPTH];

    logic [CNT_W-1:0]  occ_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;

    // Credit check and push/pop qualification; redirect and reset suppress all traffic.
    always_comb begin
        occ_s       = count_r + {{PTR_W{1'b0}}, pending_r};
        issue_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        count_nxt_s = count_r;
        if (!reset_n || bus.redirect_valid) begin
            issue_s = 1'b0;
            push_s  = 1'b0;
            pop_s   = 1'b0;
        end else begin
            // Occupancy counts the in-flight response, so a same-cycle pop frees no credit.
            issue_s = (occ_s < CNT_W'(BUF_DEPTH));
            push_s  = pending_r;
            pop_s   = out_valid_r & bus.out_ready;
        end
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Control state: fetch PC, in-flight tracking, FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_r  <= ADDR_W'(RESET_PC);
            pend_pc_r   <= ADDR_W'(RESET_PC);
            pending_r   <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc_r  <= bus.redirect_pc;
            pending_r   <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_W'(PC_STEP);
                pend_pc_r  <= fetch_pc_r;
            end
            pending_r <= issue_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    // Buffer storage; contents need no reset because out_valid gates their use.
    always_ff @(posedge clock) begin
        if (push_s) begin
            inst_mem_r[wr_ptr_r] <= bus.imem_rdata;
            pc_mem_r[wr_ptr_r]   <= pend_pc_r;
        end
    end

    assign bus.imem_req    = issue_s;
    assign bus.imem_addr   = fetch_pc_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_inst    = inst_mem_r[rd_ptr_r];
    assign bus.out_pc      = pc_mem_r[rd_ptr_r];
    assign bus.out_pc_next = pc_mem_r[rd_ptr_r] + ADDR_W'(PC_STEP);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue of issued fetch addresses (with issue cycle) predicts
// imem_req, imem_addr, out_valid and the delivered instruction stream every cycle.
module tb_fetch_unit;
    localparam int          BUF_DEPTH  = 4;
    localparam logic [15:0] RESET_PC_C = 16'h0000;

    logic clock = 1'b0;
    logic reset_n;

    fetch_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    fetch_unit #(
        .DATA_W(16), .ADDR_W(16), .PC_STEP(1), .BUF_DEPTH(BUF_DEPTH), .RESET_PC(0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] pc;
        int          cyc;
    } fetch_t;

    fetch_t      q[$];
    logic [15:0] next_pc;
    int          cyc;
    int          checks;
    int          errors;
    int          req_cnt;
    bit          model_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model at posedge.
    task automatic step(input logic rn, input logic rv, input logic [15:0] rpc, input logic rdy);
        logic        exp_req;
        logic        exp_valid;
        logic        req_seen;
        logic [15:0] addr_seen;
        logic [15:0] hp;
        reset_n            = rn;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(negedge clock);
        exp_req   = rn && !rv && (q.size() < BUF_DEPTH);
        exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        req_seen  = bus.imem_req;
        addr_seen = bus.imem_addr;
        if (model_ok) begin
            chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_req) begin
                chk("imem_addr", 32'(bus.imem_addr), 32'(next_pc));
            end
            if (exp_valid) begin
                hp = q[0].pc;
                chk("out_pc", 32'(bus.out_pc), 32'(hp));
                chk("out_inst", 32'(bus.out_inst), 32'(16'(hp + 16'h1000)));
                chk("out_pc_next", 32'(bus.out_pc_next), 32'(16'(hp + 16'h0001)));
            end
        end
        if (req_seen === 1'b1) begin
            req_cnt++;
        end
        @(posedge clock);
        if (!rn) begin
            q.delete();
            next_pc  = RESET_PC_C;
            model_ok = 1'b1;
        end else if (rv) begin
            q.delete();
            next_pc = rpc;
        end else begin
            if (exp_valid && rdy) begin
                void'(q.pop_front());
            end
            if (exp_req) begin
                q.push_back('{pc: next_pc, cyc: cyc});
                next_pc = next_pc + 16'h0001;
            end
        end
        cyc++;
        #1;
        bus.imem_rdata = (req_seen === 1'b1) ? 16'(addr_seen + 16'h1000) : 16'($urandom);
    endtask

    initial begin
        int r;
        checks   = 0;
        errors   = 0;
        req_cnt  = 0;
        cyc      = 0;
        model_ok = 1'b0;
        next_pc  = RESET_PC_C;
        reset_n  = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.out_ready      = 1'b1;
        bus.imem_rdata     = 16'h0000;
        #1;

        // Reset, then free-running stream with decode always ready.
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Decode stalled from reset: buffer fills with exactly BUF_DEPTH fetches.
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        req_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("fill_fetches", 32'(req_cnt), 32'(BUF_DEPTH));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Redirect with three buffered entries and one response in flight.
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h0040, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Back-to-back redirects, then redirect colliding with a pop.
        step(1'b1, 1'b1, 16'h0100, 1'b1);
        step(1'b1, 1'b1, 16'h0200, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b1, 16'h0080, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Address wrap at the top of the PC space.
        step(1'b1, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Mid-stream reset with a response pending.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);

        // Randomized traffic: stalls, redirects and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            step((r != 0), (r >= 1 && r <= 5), 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_W, default 16, instruction width in bits.
REQ-002 Parameter ADDR_W, default 16, PC and instruction-memory address width.
REQ-003 Parameter PC_STEP, default 1, PC increment per sequential fetch.
REQ-004 Parameter BUF_DEPTH, default 4, prefetch buffer entries; a power of two, minimum 2.
REQ-005 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-006 The module SHALL use one clock; reset is synchronous and active-low.
REQ-007 clock  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset_n  in  1  synchronous, active-low reset.
REQ-009 redirect_valid  in  1  branch/jump taken; replaces the sequential PC.
REQ-010 redirect_pc  in  ADDR_W  target address, sampled when redirect_valid=1.
REQ-011 imem_req  out  1  fetch issued this cycle.
REQ-012 imem_addr  out  ADDR_W  fetch address; meaningful when imem_req=1.
REQ-013 imem_rdata  in  DATA_W  instruction; valid exactly one cycle after its imem_req.
REQ-014 out_valid  out  1  buffer head holds a valid instruction.
REQ-015 out_ready  in  1  decode accepts the head instruction.
REQ-016 out_inst  out  DATA_W  head instruction.
REQ-017 out_pc  out  ADDR_W  address of out_inst.
REQ-018 out_pc_next  out  ADDR_W  out_pc+PC_STEP, modulo 2^ADDR_W.

Function
REQ-019 fetch_pc register SHALL hold the next address to fetch; imem_addr SHALL equal fetch_pc.
REQ-020 imem_req SHALL be 1 when count+pending < BUF_DEPTH and redirect_valid=0, else 0; count is buffer occupancy and pending is one outstanding response (0/1).
REQ-021 On each issued fetch, fetch_pc SHALL advance by PC_STEP, wrapping modulo 2^ADDR_W with no flag.
REQ-022 A response arriving in cycle t+1 for a fetch issued in cycle t SHALL be written with its PC at the end of cycle t+1, unless killed.
REQ-023 Buffer is a FIFO; out_valid=1 iff count>0, registered, with no same-cycle bypass from imem_rdata.
REQ-024 A pop occurs when out_valid=1 and out_ready=1; out_inst/out_pc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 Full: the credit rule of REQ-020 guarantees no push when count=BUF_DEPTH; a pop in the same cycle frees no credit until the next cycle.
REQ-027 Empty: out_valid=0; out_ready is ignored.
REQ-028 redirect_valid=1 in cycle t SHALL clear the buffer (count=0), kill any pending response, and set fetch_pc=redirect_pc at the end of cycle t; imem_req=0 in cycle t.
REQ-029 Redirect has priority over pop and push in the same cycle; no instruction is delivered or written in that cycle.
REQ-030 Redirect-to-out_valid latency: first fetch in t+1, write in t+2, out_valid=1 in t+3.
REQ-031 Back-to-back redirects SHALL each apply; the last one wins.
REQ-032 With out_ready held at 1 and no redirects, throughput SHALL be one instruction per cycle after the initial latency.

Reset
REQ-033 reset_n=0 at a rising edge SHALL set fetch_pc=RESET_PC, count=0, pending=0, out_valid=0, imem_req=0.
REQ-034 A response in flight when reset asserts SHALL be discarded.
REQ-035 In the first cycle after reset_n returns to 1: imem_req=1 and imem_addr=RESET_PC; out_valid=1 two cycles later.
REQ-036 out_inst, out_pc and out_pc_next are don't-care while out_valid=0.

Verification
REQ-037 Reset release with out_ready=1 and imem_rdata=addr+0x1000 -> out_pc sequence 0,1,2,... with out_inst 0x1000,0x1001,...; first out_valid two cycles after release; one per cycle thereafter.
REQ-038 out_ready=0 from reset -> exactly BUF_DEPTH fetches (0..3), then imem_req=0; out_valid=1 with out_pc=0 held; raising out_ready resumes fetches at 4.
REQ-039 Redirect to 0x0040 while the buffer holds 3 entries and a response is pending -> count=0 next cycle, killed data never appears, imem_addr=0x0040 at t+1, out_pc=0x0040 at t+3.
REQ-040 redirect_valid and out_ready both 1 with out_valid=1 -> no pop is counted; the next delivered out_pc equals redirect_pc.
REQ-041 redirect_pc=0xFFFF (ADDR_W=16, PC_STEP=1) -> out_pc 0xFFFF then 0x0000; out_pc_next at 0xFFFF equals 0x0000.
REQ-042 reset_n=0 mid-stream with a pending response -> all outputs at reset values next cycle; after release, the first out_pc=RESET_PC and the stale response never appears.
